// File: rtl/write_buffer_drain_pkg.sv
// -----------------------------------------------------------------------------
// write_buffer_drain_pkg
// Shared definitions for the write-buffer drain engine: the drain FSM state
// encoding and helpers that derive the beat geometry of a buffered line.
// -----------------------------------------------------------------------------
package write_buffer_drain_pkg;

  // Drain FSM states: wait for data, pop strobe issued, capture popped line,
  // stream beats to memory.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LOAD  = 2'd2,
    WRITE = 2'd3
  } drain_state_e;

  // Width of the completed-line counter.
  localparam int LINES_WRITTEN_WIDTH = 16;

  // Number of memory beats needed to write one buffered line.
  function automatic int calc_beats(input int line_width, input int bus_width);
    return line_width / bus_width;
  endfunction

  // Byte-address stride between consecutive beats.
  function automatic int calc_beat_bytes(input int bus_width);
    return bus_width / 8;
  endfunction

endpackage

// File: rtl/write_buffer_drain.sv
// -----------------------------------------------------------------------------
// write_buffer_drain
// Read-side engine of the data cache write buffer. Pops one line (address +
// LINE_WIDTH data) at a time, splits it into BUS_WIDTH beats and writes each
// beat to main memory over a req/ack handshake. Also reports, via a flush
// handshake, when every buffered store has reached memory.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   fifo_empty      write-buffer empty flag (registered, lags a pop by 1 cycle)
//   fifo_rd_en      one-cycle pop strobe to the write buffer
//   fifo_address    popped line base address (valid the cycle after the pop)
//   fifo_data       popped line data (valid the cycle after the pop)
//   mem_req         memory write request
//   mem_addr        beat byte address
//   mem_wdata       beat data
//   mem_ack         memory accepted the current beat
//   flush_req       level request for a full drain
//   flush_done      one-cycle pulse: buffer drained while flush_req high
//   busy            engine is not idle
//   lines_written   count of fully written lines (wraps)
// -----------------------------------------------------------------------------
module write_buffer_drain
  import write_buffer_drain_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic [ADDRESS_WIDTH-1:0]       fifo_address,
  input  logic [LINE_WIDTH-1:0]          fifo_data,
  output logic                           mem_req,
  output logic [ADDRESS_WIDTH-1:0]       mem_addr,
  output logic [BUS_WIDTH-1:0]           mem_wdata,
  input  logic                           mem_ack,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic                           busy,
  output logic [LINES_WRITTEN_WIDTH-1:0] lines_written
);

  localparam int BEATS      = calc_beats(LINE_WIDTH, BUS_WIDTH);
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BYTES = calc_beat_bytes(BUS_WIDTH);

  localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(BEAT_BYTES);

  drain_state_e                   state_q, state_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;
  logic [LINE_WIDTH-1:0]          line_q, line_d;
  logic                           mem_req_q, mem_req_d;
  logic [ADDRESS_WIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic [BUS_WIDTH-1:0]           mem_wdata_q, mem_wdata_d;
  logic [LINES_WRITTEN_WIDTH-1:0] lines_written_q, lines_written_d;
  logic [1:0]                     settle_q, settle_d;
  logic                           flush_done_q, flush_done_d;
  logic                           flush_seen_q, flush_seen_d;

  // Captured line viewed as beats; word 0 is the least significant slice.
  logic [BUS_WIDTH-1:0] line_words [BEATS];

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_line_words
    assign line_words[gi] = line_q[gi*BUS_WIDTH +: BUS_WIDTH];
  end

  // Drain FSM. mem_addr_q doubles as the running beat address: stepping it by
  // one beat stride per ack equals base + beat*stride, wrapping naturally at
  // the top of the address space.
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    line_d          = line_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    lines_written_d = lines_written_q;
    fifo_rd_en      = 1'b0;

    case (state_q)
      IDLE: begin
        // The empty flag is settled here: at least three cycles have passed
        // since the previous pop. Reset suppresses the pop strobe.
        if (!fifo_empty && !rst) begin
          fifo_rd_en = 1'b1;
          state_d    = POP;
        end
      end

      POP: begin
        state_d = LOAD;
      end

      LOAD: begin
        line_d      = fifo_data;
        beat_d      = '0;
        mem_addr_d  = fifo_address;
        mem_wdata_d = fifo_data[BUS_WIDTH-1:0];
        mem_req_d   = 1'b1;
        state_d     = WRITE;
      end

      WRITE: begin
        if (mem_ack) begin
          if (beat_q == LAST_BEAT) begin
            mem_req_d       = 1'b0;
            lines_written_d = lines_written_q + 1'b1;
            state_d         = IDLE;
          end else begin
            beat_d      = beat_q + 1'b1;
            mem_addr_d  = mem_addr_q + ADDR_STEP;
            mem_wdata_d = line_words[beat_d];
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Flush settle: count idle-and-empty cycles while flush is requested
  // (saturating at 2), pulse once on reaching 2, then stay quiet until the
  // request is withdrawn.
  always_comb begin
    settle_d = 2'd0;
    if (state_q == IDLE && flush_req && fifo_empty) begin
      settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    end
    flush_done_d = flush_req && (settle_d == 2'd2) && !flush_seen_q;
    flush_seen_d = flush_req && (flush_seen_q || flush_done_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      line_q          <= '0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      lines_written_q <= '0;
      settle_q        <= 2'd0;
      flush_done_q    <= 1'b0;
      flush_seen_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      line_q          <= line_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      lines_written_q <= lines_written_d;
      settle_q        <= settle_d;
      flush_done_q    <= flush_done_d;
      flush_seen_q    <= flush_seen_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign lines_written = lines_written_q;
  assign flush_done    = flush_done_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_write_buffer_drain.sv
// -----------------------------------------------------------------------------
// tb_write_buffer_drain
// Directed bench for write_buffer_drain: a behavioural write-buffer FIFO with a
// registered empty flag, an auto-acking memory responder with an optional
// stall on one address, and a negedge monitor that logs pops, accepted beats
// and flush pulses. Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_write_buffer_drain;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic [31:0]  fifo_address = '0;
  logic [127:0] fifo_data = '0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack = 1'b0;
  logic         flush_req = 1'b0;
  logic         flush_done;
  logic         busy;
  logic [15:0]  lines_written;

  always #5 clk = ~clk;

  write_buffer_drain #(
    .ADDRESS_WIDTH(32),
    .LINE_WIDTH   (128),
    .BUS_WIDTH    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_address (fifo_address),
    .fifo_data    (fifo_data),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .busy         (busy),
    .lines_written(lines_written)
  );

  // ---------------- write-buffer FIFO model (not reset by rst) --------------
  logic         push_en = 1'b0;
  logic [31:0]  push_addr = '0;
  logic [127:0] push_data = '0;
  logic [31:0]  fq_addr [$];
  logic [127:0] fq_data [$];

  always @(posedge clk) begin
    if (fifo_rd_en && fq_addr.size() > 0) begin
      fifo_address <= fq_addr.pop_front();
      fifo_data    <= fq_data.pop_front();
    end
    if (push_en) begin
      fq_addr.push_back(push_addr);
      fq_data.push_back(push_data);
    end
    fifo_empty <= (fq_addr.size() == 0);
  end

  // ---------------- memory responder ----------------------------------------
  logic        ack_enable = 1'b1;
  logic        ack_force  = 1'b0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  logic [31:0] stall_data = 32'h0;
  int          stall_len  = 0;
  int          stall_cnt  = 0;

  always begin
    @(posedge clk);
    #1;
    if (mem_req && mem_addr == stall_addr && stall_cnt < stall_len) begin
      mem_ack = 1'b0;
      stall_cnt++;
    end else begin
      mem_ack = ack_force || (mem_req && ack_enable);
    end
  end

  // ---------------- monitor -------------------------------------------------
  int          cyc = 0;
  int          rd_cyc [$];
  int          req_rise_cyc [$];
  int          flush_cyc [$];
  logic [31:0] beat_addr [$];
  logic [31:0] beat_data [$];
  int          last_ack_cyc = 0;
  int          stall_seen = 0;
  int          unstable = 0;
  logic        prev_req = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (fifo_rd_en) rd_cyc.push_back(cyc);
      if (mem_req && !prev_req) req_rise_cyc.push_back(cyc);
      if (mem_req && mem_ack) begin
        beat_addr.push_back(mem_addr);
        beat_data.push_back(mem_wdata);
        last_ack_cyc = cyc;
      end
      if (mem_req && !mem_ack && mem_addr == stall_addr && mem_wdata == stall_data)
        stall_seen++;
      if (prev_hold && (mem_addr != prev_addr || mem_wdata != prev_data))
        unstable++;
      if (flush_done) flush_cyc.push_back(cyc);
    end
    prev_req  = mem_req;
    prev_hold = mem_req && !mem_ack;
    prev_addr = mem_addr;
    prev_data = mem_wdata;
  end

  // ---------------- checking helpers ----------------------------------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [127:0] d);
    push_en   = 1'b1;
    push_addr = a;
    push_data = d;
    tick();
    push_en   = 1'b0;
  endtask

  task automatic clear_logs();
    rd_cyc.delete();
    req_rise_cyc.delete();
    flush_cyc.delete();
    beat_addr.delete();
    beat_data.delete();
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    logic done;
    done = 1'b0;
    tick();
    tick();
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy && !fifo_rd_en && fifo_empty && fq_addr.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_drain_in_time"}, 64'(done), 64'd1);
  endtask

  task automatic check_beat(input string tag, input int i, input logic [31:0] ea,
                            input logic [31:0] ed);
    logic [31:0] oa, od;
    oa = (i < beat_addr.size()) ? beat_addr[i] : 32'hxxxx_xxxx;
    od = (i < beat_data.size()) ? beat_data[i] : 32'hxxxx_xxxx;
    check($sformatf("%s_beat%0d_addr", tag, i), 64'(oa), 64'(ea));
    check($sformatf("%s_beat%0d_data", tag, i), 64'(od), 64'(ed));
  endtask

  // ---------------- directed sequence ---------------------------------------
  localparam logic [127:0] LINE_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  logic [31:0] exp_a_addr [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
  logic [31:0] exp_a_data [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  logic [31:0] exp_w_addr [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  logic [31:0] exp_w_data [4] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};

  initial begin
    logic got2;

    // Reset values while rst is held.
    repeat (3) tick();
    check("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_lines_written", 64'(lines_written), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Single line, ack on every request cycle.
    clear_logs();
    push(32'h1000, LINE_A);
    wait_drain("single", 60);
    check("single_pops", 64'(rd_cyc.size()), 64'd1);
    check("single_pop_to_req", 64'((rd_cyc.size() > 0 && req_rise_cyc.size() > 0) ?
          req_rise_cyc[0] - rd_cyc[0] : -1), 64'd3);
    check("single_beats", 64'(beat_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_beat("single", i, exp_a_addr[i], exp_a_data[i]);
    check("single_lines", 64'(lines_written), 64'd1);
    check("single_busy", 64'(busy), 64'd0);

    // Ack stall of 5 cycles on beat 2.
    clear_logs();
    stall_addr = 32'h1008;
    stall_data = 32'h3333_3333;
    stall_cnt  = 0;
    stall_len  = 5;
    stall_seen = 0;
    unstable   = 0;
    push(32'h1000, LINE_A);
    wait_drain("stall", 80);
    check("stall_cycles", 64'(stall_seen), 64'd5);
    check("stall_unstable", 64'(unstable), 64'd0);
    check("stall_pops", 64'(rd_cyc.size()), 64'd1);
    check("stall_beats", 64'(beat_addr.size()), 64'd4);
    check_beat("stall", 2, 32'h1008, 32'h3333_3333);
    check_beat("stall", 3, 32'h100C, 32'h4444_4444);
    check("stall_lines", 64'(lines_written), 64'd2);
    stall_len  = 0;
    stall_addr = 32'hFFFF_FFFF;

    // Three lines back to back.
    clear_logs();
    push(32'h3000, 128'hB000_0003_B000_0002_B000_0001_B000_0000);
    push(32'h3010, 128'hB000_0103_B000_0102_B000_0101_B000_0100);
    push(32'h3020, 128'hB000_0203_B000_0202_B000_0201_B000_0200);
    wait_drain("b2b", 120);
    check("b2b_pops", 64'(rd_cyc.size()), 64'd3);
    check("b2b_gap01", 64'((rd_cyc.size() > 1) ? rd_cyc[1] - rd_cyc[0] : -1), 64'd7);
    check("b2b_gap12", 64'((rd_cyc.size() > 2) ? rd_cyc[2] - rd_cyc[1] : -1), 64'd7);
    check("b2b_beats", 64'(beat_addr.size()), 64'd12);
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < 4; b++)
        check_beat("b2b", 4*k + b, 32'h3000 + 32'(16*k + 4*b), 32'hB000_0000 + 32'(256*k + b));
    check("b2b_lines", 64'(lines_written), 64'd5);
    check("b2b_busy", 64'(busy), 64'd0);

    // Address wrap at the top of the address space.
    clear_logs();
    push(32'hFFFF_FFF8, 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001);
    wait_drain("wrap", 60);
    check("wrap_beats", 64'(beat_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_beat("wrap", i, exp_w_addr[i], exp_w_data[i]);
    check("wrap_lines", 64'(lines_written), 64'd6);

    // Flush with two lines queued.
    clear_logs();
    push(32'h4000, 128'h4000_0003_4000_0002_4000_0001_4000_0000);
    push(32'h4010, 128'h4010_0003_4010_0002_4010_0001_4010_0000);
    flush_req = 1'b1;
    wait_drain("flush", 80);
    repeat (10) tick();
    check("flush_beats", 64'(beat_addr.size()), 64'd8);
    check("flush_pulses", 64'(flush_cyc.size()), 64'd1);
    check("flush_after_last_ack", 64'((flush_cyc.size() > 0) ? flush_cyc[0] - last_ack_cyc : -1),
          64'd3);
    check("flush_lines", 64'(lines_written), 64'd8);
    flush_req = 1'b0;
    repeat (2) tick();
    check("flush_rearm_quiet", 64'(flush_cyc.size()), 64'd1);
    flush_req = 1'b1;
    repeat (6) tick();
    check("flush_rearm_pulses", 64'(flush_cyc.size()), 64'd2);
    flush_req = 1'b0;
    tick();

    // Ack asserted while idle is ignored.
    ack_force = 1'b1;
    repeat (4) tick();
    check("stray_ack_req", 64'(mem_req), 64'd0);
    check("stray_ack_busy", 64'(busy), 64'd0);
    check("stray_ack_lines", 64'(lines_written), 64'd8);
    ack_force = 1'b0;
    tick();

    // Reset after beat 1 ack; the next queued line drains from beat 0.
    clear_logs();
    push(32'h5000, 128'h5000_0003_5000_0002_5000_0001_5000_0000);
    push(32'h6000, 128'h6000_0003_6000_0002_6000_0001_6000_0000);
    got2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (beat_addr.size() >= 2) begin
        got2 = 1'b1;
        break;
      end
      tick();
    end
    check("mid_two_beats_seen", 64'(got2), 64'd1);
    rst = 1'b1;
    clear_logs();
    tick();
    check("mid_rst_mem_req", 64'(mem_req), 64'd0);
    check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_flush_done", 64'(flush_done), 64'd0);
    check("mid_rst_lines", 64'(lines_written), 64'd0);
    check("mid_rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
    tick();
    rst = 1'b0;
    wait_drain("mid", 60);
    check("mid_pops", 64'(rd_cyc.size()), 64'd1);
    check("mid_beats", 64'(beat_addr.size()), 64'd4);
    check_beat("mid", 0, 32'h6000, 32'h6000_0000);
    check_beat("mid", 3, 32'h600C, 32'h6000_0003);
    check("mid_lines", 64'(lines_written), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
